// File: rtl/ex_sched_pkg.sv
// Shared types for the EX-stage issue scheduler: unit codes and the
// writeback reservation slot entry.
package ex_sched_pkg;

    typedef enum logic [1:0] {
        FU_ALU  = 2'd0,
        FU_MUL  = 2'd1,
        FU_FADD = 2'd2,
        FU_DIV  = 2'd3
    } fu_e;

    localparam int SLOT_DST_W = 5;

    typedef struct packed {
        logic                  v;
        fu_e                   fu;
        logic [SLOT_DST_W-1:0] dst;
    } slot_t;

    localparam slot_t SLOT_EMPTY = '0;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/wb_resv_table.sv
// Shifting writeback reservation table. Entry k completes k cycles from now;
// entry 0 is the registered WB tag presented this cycle.
module wb_resv_table
    import ex_sched_pkg::*;
#(
    parameter int MAXLAT = 16,
    parameter int LW     = $clog2(MAXLAT + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          i_clr,
    input  logic          i_wr_en,
    input  logic [LW-1:0] i_lat,
    input  slot_t         i_wr,
    output logic          o_probe_busy,
    output slot_t         o_head,
    output logic          o_pending
);

    slot_t r_slot [0:MAXLAT-1];

    // Probe at index L (due t+L); index MAXLAT is never occupied.
    always_comb begin
        o_probe_busy = 1'b0;
        for (int k = 1; k < MAXLAT; k++)
            if (i_lat == LW'(k)) o_probe_busy = r_slot[k].v;
    end

    always_comb begin
        o_pending = 1'b0;
        for (int k = 1; k < MAXLAT; k++)
            o_pending = o_pending | r_slot[k].v;
    end

    assign o_head = r_slot[0];

    // A new op of latency L lands at L-1 after the shift, i.e. due t+L.
    always_ff @(posedge clk) begin
        if (!reset_n || i_clr) begin
            for (int k = 0; k < MAXLAT; k++) r_slot[k] <= SLOT_EMPTY;
        end else begin
            for (int k = 0; k < MAXLAT - 1; k++) r_slot[k] <= r_slot[k+1];
            r_slot[MAXLAT-1] <= SLOT_EMPTY;
            if (i_wr_en)
                for (int k = 0; k < MAXLAT; k++)
                    if (i_lat == LW'(k + 1)) r_slot[k] <= i_wr;
        end
    end

endmodule

// File: rtl/ex_wb_scheduler.sv
// EX-stage issue scheduler: reserves the shared writeback slot per op, stalls on
// slot conflicts or a busy divider, and drives unit start strobes and WB tags.
module ex_wb_scheduler
    import ex_sched_pkg::*;
#(
    parameter int LAT_ALU  = 1,
    parameter int LAT_MUL  = 3,
    parameter int LAT_FADD = 7,
    parameter int LAT_DIV  = 16,
    parameter int DST_W    = SLOT_DST_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             issue_valid,
    input  logic [1:0]       issue_fu,
    input  logic             issue_sub,
    input  logic [DST_W-1:0] issue_dst,
    input  logic             flush,
    output logic             stall,
    output logic             alu_start,
    output logic             mul_start,
    output logic             fadd_start,
    output logic             fadd_sub,
    output logic             div_start,
    output logic             fu_kill,
    output logic             wb_valid,
    output logic [1:0]       wb_fu,
    output logic [DST_W-1:0] wb_dst,
    output logic             busy
);

    localparam int MAXLAT = max2(max2(LAT_ALU, LAT_MUL), max2(LAT_FADD, LAT_DIV));
    localparam int LW     = $clog2(MAXLAT + 1);
    localparam int DCW    = $clog2(LAT_DIV + 1);

    fu_e            w_fu;
    logic [LW-1:0]  w_lat;
    logic           w_slot_busy;
    logic           w_pending;
    logic           w_accept;
    logic           w_div_ok;
    slot_t          w_wr;
    slot_t          w_head;
    logic [DCW-1:0] r_div_cnt;
    logic           r_kill;

    assign w_fu = fu_e'(issue_fu);

    always_comb begin
        w_lat = LW'(LAT_ALU);
        case (w_fu)
            FU_ALU:  w_lat = LW'(LAT_ALU);
            FU_MUL:  w_lat = LW'(LAT_MUL);
            FU_FADD: w_lat = LW'(LAT_FADD);
            FU_DIV:  w_lat = LW'(LAT_DIV);
            default: w_lat = LW'(LAT_ALU);
        endcase
    end

    assign w_div_ok = (w_fu != FU_DIV) || (r_div_cnt == '0);
    // Reset and flush both suppress issue; flush outranks a valid op.
    assign w_accept = reset_n && issue_valid && !flush && !w_slot_busy && w_div_ok;
    assign stall    = issue_valid && !w_accept;

    assign alu_start  = w_accept && (w_fu == FU_ALU);
    assign mul_start  = w_accept && (w_fu == FU_MUL);
    assign fadd_start = w_accept && (w_fu == FU_FADD);
    assign fadd_sub   = fadd_start && issue_sub;
    assign div_start  = w_accept && (w_fu == FU_DIV);

    assign w_wr = '{v: 1'b1, fu: w_fu, dst: SLOT_DST_W'(issue_dst)};

    wb_resv_table #(.MAXLAT(MAXLAT), .LW(LW)) u_table (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_clr       (flush),
        .i_wr_en     (w_accept),
        .i_lat       (w_lat),
        .i_wr        (w_wr),
        .o_probe_busy(w_slot_busy),
        .o_head      (w_head),
        .o_pending   (w_pending)
    );

    always_ff @(posedge clk) begin
        if (!reset_n || flush)
            r_div_cnt <= '0;
        else if (div_start)
            r_div_cnt <= DCW'(LAT_DIV - 1);
        else if (r_div_cnt != '0)
            r_div_cnt <= r_div_cnt - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) r_kill <= 1'b0;
        else          r_kill <= flush;
    end

    assign fu_kill  = r_kill;
    assign wb_valid = w_head.v;
    assign wb_fu    = w_head.fu;
    assign wb_dst   = DST_W'(w_head.dst);
    assign busy     = w_pending || (r_div_cnt != '0);

endmodule

// File: tb/tb_ex_wb_scheduler.sv
// Bench for ex_wb_scheduler: directed scenarios with literal expectations, then
// random traffic against a per-absolute-cycle writeback calendar model.
module tb_ex_wb_scheduler;

    localparam int LA = 1, LM = 3, LF = 7, LD = 16, MAXL = 16, NC = 8192;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       issue_valid = 1'b0;
    logic [1:0] issue_fu = 2'd0;
    logic       issue_sub = 1'b0;
    logic [4:0] issue_dst = 5'd0;
    logic       flush = 1'b0;
    logic       stall, alu_start, mul_start, fadd_start, fadd_sub, div_start;
    logic       fu_kill, wb_valid, busy;
    logic [1:0] wb_fu;
    logic [4:0] wb_dst;

    ex_wb_scheduler #(.LAT_ALU(LA), .LAT_MUL(LM), .LAT_FADD(LF), .LAT_DIV(LD), .DST_W(5)) dut (
        .clk(clk), .reset_n(reset_n), .issue_valid(issue_valid), .issue_fu(issue_fu),
        .issue_sub(issue_sub), .issue_dst(issue_dst), .flush(flush), .stall(stall),
        .alu_start(alu_start), .mul_start(mul_start), .fadd_start(fadd_start),
        .fadd_sub(fadd_sub), .div_start(div_start), .fu_kill(fu_kill), .wb_valid(wb_valid),
        .wb_fu(wb_fu), .wb_dst(wb_dst), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    // Calendar model: what the WB port must show at each absolute cycle.
    bit due_v   [0:NC-1];
    int due_fu  [0:NC-1];
    int due_dst [0:NC-1];
    int div_free = 0;
    bit prev_kill = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d cycle=%0d", nm, act, exp, cyc);
        end
    endtask

    function automatic int lat_of(input int fu);
        case (fu)
            0: return LA;
            1: return LM;
            2: return LF;
            default: return LD;
        endcase
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            int  l;
            bit  acc, pend;
            int  fu;
            fu  = int'(issue_fu);
            l   = lat_of(fu);
            acc = reset_n && issue_valid && !flush && !due_v[cyc+l] && (fu != 3 || cyc >= div_free);
            chk("stall", stall, int'(issue_valid && !acc));
            chk("alu_start", alu_start, int'(acc && fu == 0));
            chk("mul_start", mul_start, int'(acc && fu == 1));
            chk("fadd_start", fadd_start, int'(acc && fu == 2));
            chk("fadd_sub", fadd_sub, int'(acc && fu == 2 && issue_sub));
            chk("div_start", div_start, int'(acc && fu == 3));
            chk("wb_valid", wb_valid, int'(due_v[cyc]));
            if (due_v[cyc]) begin
                chk("wb_fu", int'(wb_fu), due_fu[cyc]);
                chk("wb_dst", int'(wb_dst), due_dst[cyc]);
            end
            chk("fu_kill", fu_kill, int'(prev_kill));
            pend = 1'b0;
            for (int c = cyc + 1; c <= cyc + MAXL; c++) pend = pend | due_v[c];
            chk("busy", busy, int'(pend || (div_free - cyc >= 1 && div_free - cyc <= LD - 1)));
            if (!reset_n || flush) begin
                for (int c = cyc + 1; c <= cyc + MAXL; c++) due_v[c] = 1'b0;
                div_free = 0;
            end else if (acc) begin
                due_v[cyc+l]   = 1'b1;
                due_fu[cyc+l]  = fu;
                due_dst[cyc+l] = int'(issue_dst);
                if (fu == 3) div_free = cyc + LD;
            end
            prev_kill = flush && reset_n;
        end
        cyc++;
    end

    task automatic drive(input bit v, input int fu, input bit sub, input int dst, input bit fl);
        @(posedge clk);
        #1;
        issue_valid = v;
        issue_fu    = 2'(fu);
        issue_sub   = sub;
        issue_dst   = 5'(dst);
        flush       = fl;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 0, 1'b0, 0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset held with a valid op presented
        drive(1'b1, 0, 1'b0, 1, 1'b0);
        reset_n = 1'b0;
        #1 chk("t1_alu_start_rst", alu_start, 0);
        drive(1'b1, 0, 1'b0, 1, 1'b0);
        chk_en = 1'b1;
        #1 chk("t1_alu_start_rst2", alu_start, 0);
        chk("t1_busy", busy, 0);
        chk("t1_wb_valid", wb_valid, 0);
        drive(1'b0, 0, 1'b0, 0, 1'b0);
        reset_n = 1'b1;
        #1 chk("t1_wb_fu", int'(wb_fu), 0);
        chk("t1_wb_dst", int'(wb_dst), 0);
        chk("t1_fu_kill", fu_kill, 0);
        idle(2);

        // 2: single ALU
        drive(1'b1, 0, 1'b0, 3, 1'b0);
        #1 chk("t2_alu_start", alu_start, 1);
        drive(1'b0, 0, 1'b0, 0, 1'b0);
        #1 chk("t2_wb_valid", wb_valid, 1);
        chk("t2_wb_fu", int'(wb_fu), 0);
        chk("t2_wb_dst", int'(wb_dst), 3);
        drive(1'b0, 0, 1'b0, 0, 1'b0);
        #1 chk("t2_wb_off", wb_valid, 0);

        // 3: MUL then ALU colliding on the same WB slot
        idle(3);
        drive(1'b1, 1, 1'b0, 4, 1'b0);
        drive(1'b0, 0, 1'b0, 0, 1'b0);
        drive(1'b1, 0, 1'b0, 5, 1'b0);
        #1 chk("t3_stall", stall, 1);
        chk("t3_no_alu", alu_start, 0);
        drive(1'b1, 0, 1'b0, 5, 1'b0);
        #1 chk("t3_alu_late", alu_start, 1);
        chk("t3_wb_dst4", int'(wb_dst), 4);
        drive(1'b0, 0, 1'b0, 0, 1'b0);
        #1 chk("t3_wb_dst5", int'(wb_dst), 5);
        chk("t3_wb_v5", wb_valid, 1);

        // 4: back-to-back FADD
        idle(3);
        drive(1'b1, 2, 1'b1, 7, 1'b0);
        #1 chk("t4_fsub1", fadd_sub, 1);
        drive(1'b1, 2, 1'b0, 8, 1'b0);
        #1 chk("t4_fstart2", fadd_start, 1);
        chk("t4_fsub0", fadd_sub, 0);
        idle(6);
        #1 chk("t4_wb7", int'(wb_dst), 7);
        chk("t4_wbv7", wb_valid, 1);
        drive(1'b0, 0, 1'b0, 0, 1'b0);
        #1 chk("t4_wb8", int'(wb_dst), 8);

        // 5: DIV lockout
        idle(3);
        drive(1'b1, 3, 1'b0, 9, 1'b0);
        #1 chk("t5_div1", div_start, 1);
        for (int i = 1; i < 16; i++) begin
            drive(1'b1, 3, 1'b0, 10, 1'b0);
            #1 chk("t5_stall", stall, 1);
        end
        drive(1'b1, 3, 1'b0, 10, 1'b0);
        #1 chk("t5_div2", div_start, 1);
        chk("t5_wb9", int'(wb_dst), 9);
        idle(16);
        #1 chk("t5_wb10", int'(wb_dst), 10);
        chk("t5_wbv10", wb_valid, 1);

        // 6: flush kills in-flight MUL and beats a valid ALU
        idle(3);
        drive(1'b1, 1, 1'b0, 2, 1'b0);
        drive(1'b1, 0, 1'b0, 6, 1'b1);
        #1 chk("t6_no_alu", alu_start, 0);
        chk("t6_stall", stall, 1);
        drive(1'b0, 0, 1'b0, 0, 1'b0);
        #1 chk("t6_kill", fu_kill, 1);
        chk("t6_busy", busy, 0);
        chk("t6_wb_off", wb_valid, 0);
        idle(3);

        // Result due in the flush cycle itself still appears
        drive(1'b1, 0, 1'b0, 11, 1'b0);
        drive(1'b0, 0, 1'b0, 0, 1'b1);
        #1 chk("t7_wb_flushcyc", wb_valid, 1);
        chk("t7_wb_dst", int'(wb_dst), 11);
        drive(1'b0, 0, 1'b0, 0, 1'b0);
        #1 chk("t7_kill", fu_kill, 1);

        // Random traffic with occasional flush and mid-run reset
        for (int i = 0; i < 2500; i++) begin
            drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 31)), $urandom_range(0, 39) == 0);
            reset_n = ($urandom_range(0, 199) != 0);
        end
        reset_n = 1'b1;
        idle(20);
        @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
